// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Constants, state type and feedback function shared by the PRBS9 pattern
// generator and the PRBS9 checker.
//   PRBS_ORDER     : shift register length (9)
//   TAP_A, TAP_B   : history taps combined by the XNOR feedback
//   prbs_state_e   : checker synchronisation states
//   prbs_feedback(): next sequence bit predicted from a history register
//                    whose newest bit sits at the MSB
// -----------------------------------------------------------------------------
package prbs_pkg;

  localparam int PRBS_ORDER = 9;
  localparam int TAP_A      = 0;
  localparam int TAP_B      = 4;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } prbs_state_e;

  // XNOR form: s[n] = ~(s[n-9] ^ s[n-5]). With the newest bit in the MSB,
  // s[n-9] is bit TAP_A and s[n-5] is bit TAP_B.
  function automatic logic prbs_feedback(input logic [PRBS_ORDER-1:0] sr);
    return ~(sr[TAP_A] ^ sr[TAP_B]);
  endfunction

endpackage

// File: rtl/prbs9_predict.sv
// -----------------------------------------------------------------------------
// prbs9_predict
// Holds the 9-bit PRBS history and produces the predicted next bit.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   shift_en   : shift one bit into the history this cycle
//   sel_pred   : 1 = shift in the prediction (free-running reference),
//                0 = shift in the received bit (self-synchronising)
//   bit_in     : received bit
//   p          : predicted bit for the current history
//   lockup     : history is all ones (XNOR lock-up state)
// -----------------------------------------------------------------------------
module prbs9_predict
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic sel_pred,
  input  logic bit_in,
  output logic p,
  output logic lockup
);

  logic [PRBS_ORDER-1:0] sr;
  logic                  shift_bit;

  assign p         = prbs_feedback(sr);
  assign lockup    = &sr;
  assign shift_bit = sel_pred ? p : bit_in;

  // History shifts right; the newest bit enters the MSB.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= {shift_bit, sr[PRBS_ORDER-1:1]};
    end
  end

endmodule

// File: rtl/prbs9_checker.sv
// -----------------------------------------------------------------------------
// prbs9_checker
// Self-synchronising PRBS9 (XNOR, period 511) bit-error checker for the
// QPSK receive path. Hunts for nine history bits, requires LOCK_COUNT
// consecutive correct predictions, then checks against a free-running local
// reference and counts bit errors and checked bits for BER measurement.
//
// Parameters
//   LOCK_COUNT  : consecutive matches in SYNC needed to declare lock
//   CNT_WIDTH   : width of err_count / bit_count (both saturate)
//   WINDOW      : loss-of-lock observation window, in valid bits
//   LOSS_THRESH : errors within one window that force a relock
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   bit_in     : received bit
//   bit_valid  : bit_in qualifier; nothing changes on cycles where it is low
//   clear      : synchronous clear of err_count and bit_count
//   locked     : high while in LOCKED
//   err_pulse  : one-cycle pulse per errored bit counted in LOCKED
//   err_count  : cumulative errors (saturating)
//   bit_count  : cumulative bits checked in LOCKED (saturating)
//
// Build option
//   PRBS9_CHECKER_RELOCK_EN : when defined, LOSS_THRESH errors within a
//   WINDOW-bit window in LOCKED send the checker back to HUNT. When
//   undefined, the window logic is absent and LOCKED holds until reset.
// -----------------------------------------------------------------------------
module prbs9_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int WINDOW      = 128,
  parameter int LOSS_THRESH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] bit_count
);

  localparam int FILL_W  = $clog2(PRBS_ORDER);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

  // The window parameters must stay consistent even when relock is not
  // built, so one parameter set serves both variants.
  if (LOSS_THRESH < 1 || LOSS_THRESH > WINDOW) begin : g_bad_window_cfg
    $error("prbs9_checker: LOSS_THRESH must be in 1..WINDOW");
  end

  prbs_state_e          state;
  logic [FILL_W-1:0]    fill_cnt;
  logic [MATCH_W-1:0]   match_cnt;

  logic p;
  logic lockup;
  logic mismatch;
  logic lock_enter;
  logic loss;
  logic count_bit;
  logic count_err;

  // In LOCKED the history runs on its own predictions, so a channel error
  // never enters the reference and is counted exactly once.
  prbs9_predict u_predict (
    .clk      (clk),
    .reset    (reset),
    .shift_en (bit_valid),
    .sel_pred (state == LOCKED),
    .bit_in   (bit_in),
    .p        (p),
    .lockup   (lockup)
  );

  assign mismatch   = bit_in ^ p;
  assign lock_enter = bit_valid && (state == SYNC) && !lockup && !mismatch &&
                      (match_cnt == MATCH_W'(LOCK_COUNT - 1));
  assign count_bit  = bit_valid && (state == LOCKED);
  assign count_err  = count_bit && mismatch;

`ifdef PRBS9_CHECKER_RELOCK_EN
  localparam int WIN_W  = $clog2(WINDOW + 1);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  logic [WIN_W-1:0]  win_cnt;
  logic [WERR_W-1:0] win_err;
  logic [WERR_W-1:0] win_err_inc;

  assign win_err_inc = win_err + WERR_W'(mismatch);
  // The bit that reaches the threshold ends lock, even on the last bit of a
  // window.
  assign loss = count_err && (win_err_inc == WERR_W'(LOSS_THRESH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (lock_enter) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (count_bit) begin
      if (win_cnt == WIN_W'(WINDOW - 1)) begin
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        win_err <= win_err_inc;
      end
    end
  end
`else
  assign loss = 1'b0;
`endif

  // Synchronisation FSM; locked is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      fill_cnt  <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
    end else if (bit_valid) begin
      case (state)
        HUNT: begin
          if (fill_cnt == FILL_W'(PRBS_ORDER - 1)) begin
            state     <= SYNC;
            match_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        SYNC: begin
          // An all-ones history predicts ones forever; restart the hunt.
          if (lockup) begin
            state    <= HUNT;
            fill_cnt <= '0;
          end else if (mismatch) begin
            match_cnt <= '0;
          end else if (lock_enter) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else begin
            match_cnt <= match_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (loss) begin
            state    <= HUNT;
            fill_cnt <= '0;
            locked   <= 1'b0;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Error/bit counters. clear wins over a same-cycle increment, but the
  // error pulse still reports the errored bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= count_err;
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
      end else begin
        if (count_err && !(&err_count)) err_count <= err_count + 1'b1;
        if (count_bit && !(&bit_count)) bit_count <= bit_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs9_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs9_checker
// Directed and randomized stimulus for prbs9_checker. Two instances share the
// inputs: one with 32-bit counters and one with 4-bit counters for
// saturation. Expected values come from a behavioural model that tracks the
// received history as a queue and derives predictions from the sequence
// recurrence.
// -----------------------------------------------------------------------------
module tb_prbs9_checker;

  localparam int LOCK_COUNT  = 32;
  localparam int WINDOW      = 128;
  localparam int LOSS_THRESH = 16;
  localparam int SAT_W       = 4;

  localparam int M_HUNT   = 0;
  localparam int M_SYNC   = 1;
  localparam int M_LOCKED = 2;

  logic              clk;
  logic              reset;
  logic              bit_in;
  logic              bit_valid;
  logic              clear;
  logic              locked;
  logic              err_pulse;
  logic [31:0]       err_count;
  logic [31:0]       bit_count;
  logic              s_locked;
  logic              s_err_pulse;
  logic [SAT_W-1:0]  s_err_count;
  logic [SAT_W-1:0]  s_bit_count;

  prbs9_checker #(
    .LOCK_COUNT(LOCK_COUNT), .CNT_WIDTH(32), .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH)
  ) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
  );

  prbs9_checker #(
    .LOCK_COUNT(LOCK_COUNT), .CNT_WIDTH(SAT_W), .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH)
  ) dut_sat (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
    .bit_count(s_bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference PRBS9 pattern, seed 0: nine zeros then the recurrence.
  bit seq [511];
  int tx_idx;

  // Behavioural model
  int     m_state;
  int     m_fill;
  int     m_match;
  int     m_wcnt;
  int     m_werr;
  bit     m_hist[$];      // oldest first: m_hist[0] = s[n-9]
  longint m_errs;
  longint m_bits;
  bit     m_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (64'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_reset();
    m_state = M_HUNT;
    m_fill  = 0;
    m_match = 0;
    m_wcnt  = 0;
    m_werr  = 0;
    m_errs  = 0;
    m_bits  = 0;
    m_pulse = 0;
    m_hist  = {};
    repeat (9) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_push(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endfunction

  function automatic void model_step(input bit b, input bit v, input bit clr);
    bit pred;
    bit miss;
    bit all1;
    m_pulse = 0;
    if (v) begin
      pred = !(m_hist[0] ^ m_hist[4]);
      miss = (b != pred);
      all1 = 1;
      foreach (m_hist[i]) if (!m_hist[i]) all1 = 0;
      case (m_state)
        M_HUNT: begin
          model_push(b);
          m_fill++;
          if (m_fill == 9) begin
            m_state = M_SYNC;
            m_match = 0;
          end
        end
        M_SYNC: begin
          model_push(b);
          if (all1) begin
            m_state = M_HUNT;
            m_fill  = 0;
          end else if (miss) begin
            m_match = 0;
          end else begin
            m_match++;
            if (m_match == LOCK_COUNT) begin
              m_state = M_LOCKED;
              m_wcnt  = 0;
              m_werr  = 0;
            end
          end
        end
        default: begin
          model_push(pred);
          m_bits++;
          if (miss) begin
            m_errs++;
            m_pulse = 1;
          end
`ifdef PRBS9_CHECKER_RELOCK_EN
          if (miss) m_werr++;
          if (m_werr == LOSS_THRESH) begin
            m_state = M_HUNT;
            m_fill  = 0;
          end else begin
            m_wcnt++;
            if (m_wcnt == WINDOW) begin
              m_wcnt = 0;
              m_werr = 0;
            end
          end
`endif
        end
      endcase
    end
    if (clr) begin
      m_errs = 0;
      m_bits = 0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_locked"},     32'(locked),      32'(m_state == M_LOCKED));
    check({tag, "_err_pulse"},  32'(err_pulse),   32'(m_pulse));
    check({tag, "_err_count"},  err_count,        32'(sat(m_errs, 32)));
    check({tag, "_bit_count"},  bit_count,        32'(sat(m_bits, 32)));
    check({tag, "_sat_err"},    32'(s_err_count), 32'(sat(m_errs, SAT_W)));
    check({tag, "_sat_bit"},    32'(s_bit_count), 32'(sat(m_bits, SAT_W)));
  endtask

  task automatic step(input bit b, input bit v, input bit clr, input string tag);
    bit_in    = b;
    bit_valid = v;
    clear     = clr;
    @(posedge clk);
    #1;
    model_step(b, v, clr);
    check_outputs(tag);
  endtask

  // Sends the next pattern bit (optionally inverted) or an idle cycle.
  task automatic send(input bit inv, input bit v, input bit clr, input string tag);
    bit b;
    if (v) begin
      b = seq[tx_idx % 511] ^ inv;
      tx_idx++;
    end else begin
      b = 1'($urandom_range(1, 0));
    end
    step(b, v, clr, tag);
  endtask

  task automatic send_clean(input int n, input string tag);
    repeat (n) send(1'b0, 1'b1, 1'b0, tag);
  endtask

  task automatic do_reset();
    bit_valid = 0;
    clear     = 0;
    bit_in    = 0;
    #2 reset  = 1;
    #1;
    model_reset();
    tx_idx = 0;
    check_outputs("async_reset");
    @(posedge clk);
    #2 reset = 0;
  endtask

  initial begin
    int n_valid;
    int lock_at;
    bit v;
    bit inv;

    reset = 1;
    bit_in = 0;
    bit_valid = 0;
    clear = 0;
    for (int i = 0; i < 511; i++) seq[i] = (i < 9) ? 1'b0 : !(seq[i-9] ^ seq[i-5]);

    // Clean lock: rises right after valid bit 41
    do_reset();
    send_clean(40, "acquire");
    check("lock_pre_41", 32'(locked), 32'd0);
    send_clean(1, "acquire");
    check("lock_at_41", 32'(locked), 32'd1);
    send_clean(10, "locked_clean");

    // One inverted bit in LOCKED: single pulse, no follow-on errors
    send(1'b1, 1'b1, 1'b0, "single_err");
    check("single_err_pulse", 32'(err_pulse), 32'd1);
    check("single_err_count", err_count, 32'd1);
    send_clean(20, "after_single");
    check("after_single_count", err_count, 32'd1);
    check("after_single_locked", 32'(locked), 32'd1);

    // Mismatch at the 32nd SYNC prediction restarts the match run
    do_reset();
    send_clean(40, "sync_run");
    send(1'b1, 1'b1, 1'b0, "sync_break");
    send_clean(31, "sync_resume");
    check("sync_break_not_locked", 32'(locked), 32'd0);
    send_clean(29, "sync_resume");
    check("sync_break_relocked", 32'(locked), 32'd1);

    // 16 errors inside one window after lock
    do_reset();
    send_clean(41, "win_acquire");
    for (int e = 0; e < 16; e++) begin
      send_clean(3, "win_clean");
      send(1'b1, 1'b1, 1'b0, "win_err");
    end
    check("win_err_count", err_count, 32'd16);
`ifdef PRBS9_CHECKER_RELOCK_EN
    check("win_lost", 32'(locked), 32'd0);
    send_clean(40, "relock");
    check("relock_pre", 32'(locked), 32'd0);
    send_clean(1, "relock");
    check("relock_done", 32'(locked), 32'd1);
    check("relock_keeps_count", err_count, 32'd16);
`else
    check("win_stays_locked", 32'(locked), 32'd1);
    send_clean(41, "terminal_lock");
    check("terminal_lock_held", 32'(locked), 32'd1);
`endif

    // clear together with an error; then saturation of the 4-bit counters
    send_clean(5, "pre_clear");
    send(1'b1, 1'b1, 1'b1, "clear_err");
    check("clear_err_pulse", 32'(err_pulse), 32'd1);
    check("clear_err_count", err_count, 32'd0);
    for (int e = 0; e < 20; e++) begin
      send_clean(9, "sat_clean");
      send(1'b1, 1'b1, 1'b0, "sat_err");
    end
    check("sat_err_32", err_count, 32'd20);
    check("sat_err_4", 32'(s_err_count), 32'd15);
    check("sat_bit_4", 32'(s_bit_count), 32'd15);

    // Asynchronous reset in LOCKED clears outputs before any clock edge
    check("pre_reset_locked", 32'(locked), 32'd1);
    do_reset();
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_err_count", err_count, 32'd0);

    // All-ones input never locks
    repeat (80) step(1'b1, 1'b1, 1'b0, "all_ones");
    check("all_ones_no_lock", 32'(locked), 32'd0);

    // Random 50% valid gaps, random errors once locked
    do_reset();
    n_valid = 0;
    lock_at = -1;
    repeat (600) begin
      v   = 1'($urandom_range(1, 0));
      inv = (m_state == M_LOCKED) && ($urandom_range(31, 0) == 0);
      send(inv, v, 1'b0, "gaps");
      if (v) n_valid++;
      if (locked && lock_at < 0) lock_at = n_valid;
    end
    check("gap_lock_point", 32'(lock_at), 32'd41);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
